// File: rtl/rvr32_mem_pkg.sv
// Shared definitions for the rvr32 memory-side blocks: default bus widths,
// the load/store arbiter state encoding and a small modulo-increment helper.
package rvr32_mem_pkg;

  localparam int RVR32_AW = 32;
  localparam int RVR32_DW = 32;

  localparam logic LSA_IDLE   = 1'b0;
  localparam logic LSA_LOCKED = 1'b1;

  typedef enum logic {
    ST_IDLE   = LSA_IDLE,
    ST_LOCKED = LSA_LOCKED
  } lsa_state_e;

  // Next port index after v, wrapping back to 0 at n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rvr32_lsa_np_if.sv
// Bundle of requester-side and memory-side signals around the N-port
// load/store arbiter; slave is the arbiter's view, master the environment's.
interface rvr32_lsa_np_if
  import rvr32_mem_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = RVR32_AW,
  parameter int DW     = RVR32_DW
);

  logic [NPORTS-1:0]        valid;
  logic [NPORTS*AW-1:0]     addr;
  logic [NPORTS*DW-1:0]     wdata;
  logic [NPORTS*DW/8-1:0]   wstrb;
  logic [NPORTS-1:0]        ready;
  logic [DW-1:0]            rdata;

  logic                     mem_valid;
  logic [AW-1:0]            mem_addr;
  logic [DW-1:0]            mem_wdata;
  logic [DW/8-1:0]          mem_wstrb;
  logic                     mem_ready;
  logic [DW-1:0]            mem_rdata;

  modport slave (
    input  valid, addr, wdata, wstrb, mem_ready, mem_rdata,
    output ready, rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output valid, addr, wdata, wstrb, mem_ready, mem_rdata,
    input  ready, rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/rvr32_rr_pick.sv
// Combinational requester picker: first asserted request scanning upward
// from ptr (round-robin) or from index 0 (fixed priority), wrapping at NPORTS.
module rvr32_rr_pick #(
  parameter int NPORTS = 2,
  parameter int IDXW   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  input  logic              rr_en,
  output logic [IDXW-1:0]   gnt_idx,
  output logic              gnt_any
);

  int start_i;
  int idx_i;

  // Out-of-range pointers cannot occur, but fold them to 0 so the scan stays bounded.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_i   = 0;
    start_i = rr_en ? int'(ptr) : 0;
    if (start_i >= NPORTS) begin
      start_i = 0;
    end
    for (int k = 0; k < NPORTS; k++) begin
      idx_i = start_i + k;
      if (idx_i >= NPORTS) begin
        idx_i = idx_i - NPORTS;
      end
      if (!gnt_any && req[idx_i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDXW'(idx_i);
      end
    end
  end

endmodule

// File: rtl/rvr32_lsa_np.sv
// N-port load/store arbiter sharing one valid/ready memory port; a grant that
// stalls on mem_ready is locked to its port until completion.
module rvr32_lsa_np
  import rvr32_mem_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = RVR32_AW,
  parameter int DW     = RVR32_DW,
  parameter int RR_EN  = 1,
  localparam int IDXW  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  rvr32_lsa_np_if.slave     bus,
  output logic              busy,
  output logic [IDXW-1:0]   grant_idx
);

  localparam int SW = DW / 8;

  lsa_state_e      state, state_d;
  logic [IDXW-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] rr_ptr, ptr_d;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            locked;
  logic [IDXW-1:0] sel;
  logic            sel_valid;

  logic              mem_valid_d;
  logic [AW-1:0]     mem_addr_d;
  logic [DW-1:0]     mem_wdata_d;
  logic [SW-1:0]     mem_wstrb_d;
  logic [NPORTS-1:0] ready_d;

  rvr32_rr_pick #(
    .NPORTS (NPORTS),
    .IDXW   (IDXW)
  ) u_pick (
    .req     (bus.valid),
    .ptr     (rr_ptr),
    .rr_en   (RR_EN != 0),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Once locked, only the held port may drive the memory; a dropped valid
  // there releases the bus immediately without signalling completion.
  always_comb begin
    locked      = (state == ST_LOCKED);
    sel         = locked ? gnt_q : pick_idx;
    sel_valid   = locked ? bus.valid[gnt_q] : pick_any;
    mem_valid_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wstrb_d = '0;
    ready_d     = '0;
    grant_idx   = '0;
    busy        = !rst && locked;
    if (!rst && sel_valid) begin
      mem_valid_d  = 1'b1;
      mem_addr_d   = bus.addr[int'(sel)*AW +: AW];
      mem_wdata_d  = bus.wdata[int'(sel)*DW +: DW];
      mem_wstrb_d  = bus.wstrb[int'(sel)*SW +: SW];
      ready_d[sel] = bus.mem_ready;
      grant_idx    = sel;
    end
  end

  assign bus.mem_valid = mem_valid_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_wstrb = mem_wstrb_d;
  assign bus.ready     = ready_d;
  assign bus.rdata     = bus.mem_rdata;

  // The round-robin pointer only moves on a real completion, never on an abort.
  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    ptr_d   = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          if (bus.mem_ready) begin
            ptr_d = IDXW'(wrap_inc(int'(pick_idx), NPORTS));
          end else begin
            state_d = ST_LOCKED;
            gnt_d   = pick_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (!bus.valid[gnt_q]) begin
          state_d = ST_IDLE;
        end else if (bus.mem_ready) begin
          state_d = ST_IDLE;
          ptr_d   = IDXW'(wrap_inc(int'(gnt_q), NPORTS));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_d;
      gnt_q  <= gnt_d;
      rr_ptr <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rvr32_lsa_np.sv
// Directed bench: a round-robin and a fixed-priority 3-port arbiter share one
// stimulus stream; each step sets inputs after a rising edge and checks before the next.
module tb_rvr32_lsa_np;
  import rvr32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  valid;
  logic [95:0] addr;
  logic [95:0] wdata;
  logic [11:0] wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        busy_rr, busy_fp;
  logic [1:0]  gidx_rr, gidx_fp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rvr32_lsa_np_if #(.NPORTS(3), .AW(32), .DW(32)) rr_if ();
  rvr32_lsa_np_if #(.NPORTS(3), .AW(32), .DW(32)) fp_if ();

  assign rr_if.valid     = valid;
  assign rr_if.addr      = addr;
  assign rr_if.wdata     = wdata;
  assign rr_if.wstrb     = wstrb;
  assign rr_if.mem_ready = mem_ready;
  assign rr_if.mem_rdata = mem_rdata;
  assign fp_if.valid     = valid;
  assign fp_if.addr      = addr;
  assign fp_if.wdata     = wdata;
  assign fp_if.wstrb     = wstrb;
  assign fp_if.mem_ready = mem_ready;
  assign fp_if.mem_rdata = mem_rdata;

  rvr32_lsa_np #(.NPORTS(3), .AW(32), .DW(32), .RR_EN(1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .bus       (rr_if.slave),
    .busy      (busy_rr),
    .grant_idx (gidx_rr)
  );

  rvr32_lsa_np #(.NPORTS(3), .AW(32), .DW(32), .RR_EN(0)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .bus       (fp_if.slave),
    .busy      (busy_fp),
    .grant_idx (gidx_fp)
  );

  task automatic applyStimulus(input logic r, input logic [2:0] v, input logic mr);
    @(posedge clk);
    #1;
    rst       = r;
    valid     = v;
    mem_ready = mr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    valid     = 3'b111;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    addr      = {32'h0000_0200, 32'h0000_0100, 32'h0000_0040};
    wdata     = {32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
    wstrb     = {4'h3, 4'hF, 4'h0};

    // Reset with every port requesting: outputs forced low, rdata still broadcast
    applyStimulus(1'b1, 3'b111, 1'b1);
    applyStimulus(1'b1, 3'b111, 1'b1);
    checkOutput("rst_mem_valid", rr_if.mem_valid, 1'b0);
    checkOutput("rst_ready", rr_if.ready, 3'b000);
    checkOutput("rst_busy", busy_rr, 1'b0);
    checkOutput("rst_grant_idx", gidx_rr, 2'd0);
    checkOutput("rst_mem_addr", rr_if.mem_addr, 32'h0);
    checkOutput("rst_rdata", rr_if.rdata, 32'hCAFE_F00D);
    checkOutput("rst_fp_mem_valid", fp_if.mem_valid, 1'b0);

    // Release: port 0 first, then round-robin 1,2,0,1,2 with mem_ready every cycle
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("rr_first_ready", rr_if.ready, 3'b001);
    checkOutput("rr_first_addr", rr_if.mem_addr, 32'h40);
    checkOutput("rr_first_wstrb", rr_if.mem_wstrb, 4'h0);
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("rr_seq1", rr_if.ready, 3'b010);
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("rr_seq2", rr_if.ready, 3'b100);
    checkOutput("rr_seq2_addr", rr_if.mem_addr, 32'h200);
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("rr_seq3", rr_if.ready, 3'b001);
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("rr_seq4", rr_if.ready, 3'b010);
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("rr_seq5", rr_if.ready, 3'b100);

    // Lock: port 1 stalls three cycles while port 0 joins; completes on cycle 4
    applyStimulus(1'b0, 3'b010, 1'b0);
    checkOutput("lock_c1_addr", rr_if.mem_addr, 32'h100);
    checkOutput("lock_c1_ready", rr_if.ready, 3'b000);
    checkOutput("lock_c1_busy", busy_rr, 1'b0);
    applyStimulus(1'b0, 3'b011, 1'b0);
    checkOutput("lock_c2_addr", rr_if.mem_addr, 32'h100);
    checkOutput("lock_c2_busy", busy_rr, 1'b1);
    checkOutput("lock_c2_gidx", gidx_rr, 2'd1);
    checkOutput("lock_c2_wdata", rr_if.mem_wdata, 32'hD1);
    checkOutput("lock_c2_wstrb", rr_if.mem_wstrb, 4'hF);
    applyStimulus(1'b0, 3'b011, 1'b0);
    checkOutput("lock_c3_addr", rr_if.mem_addr, 32'h100);
    checkOutput("lock_c3_ready", rr_if.ready, 3'b000);
    applyStimulus(1'b0, 3'b011, 1'b1);
    checkOutput("lock_c4_ready", rr_if.ready, 3'b010);
    checkOutput("lock_c4_addr", rr_if.mem_addr, 32'h100);
    checkOutput("lock_c4_busy", busy_rr, 1'b1);
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("lock_next_ready", rr_if.ready, 3'b001);
    checkOutput("lock_next_busy", busy_rr, 1'b0);
    checkOutput("lock_next_addr", rr_if.mem_addr, 32'h40);

    // Wrap: pointer at 2 with only port 1 valid scans 2,0,1
    applyStimulus(1'b0, 3'b010, 1'b1);
    checkOutput("wrap_pre_ready", rr_if.ready, 3'b010);
    applyStimulus(1'b0, 3'b010, 1'b1);
    checkOutput("wrap_ready", rr_if.ready, 3'b010);

    // Abort: lock port 2 then drop its valid
    applyStimulus(1'b0, 3'b100, 1'b0);
    checkOutput("abort_lock_addr", rr_if.mem_addr, 32'h200);
    applyStimulus(1'b0, 3'b100, 1'b0);
    checkOutput("abort_locked_busy", busy_rr, 1'b1);
    checkOutput("abort_locked_gidx", gidx_rr, 2'd2);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("abort_mem_valid", rr_if.mem_valid, 1'b0);
    checkOutput("abort_ready", rr_if.ready, 3'b000);
    checkOutput("abort_mem_addr", rr_if.mem_addr, 32'h0);
    checkOutput("abort_mem_wdata", rr_if.mem_wdata, 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("abort_idle_busy", busy_rr, 1'b0);
    checkOutput("idle_mem_valid", rr_if.mem_valid, 1'b0);
    checkOutput("idle_grant_idx", gidx_rr, 2'd0);
    applyStimulus(1'b0, 3'b110, 1'b1);
    checkOutput("abort_ptr_kept", rr_if.ready, 3'b100);

    // Mid-transfer reset: port 1 locked, one reset cycle, arbitration restarts at 0
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("mrst_pre_ready", rr_if.ready, 3'b001);
    applyStimulus(1'b0, 3'b010, 1'b0);
    checkOutput("mrst_req_addr", rr_if.mem_addr, 32'h100);
    applyStimulus(1'b0, 3'b010, 1'b0);
    checkOutput("mrst_locked_busy", busy_rr, 1'b1);
    checkOutput("mrst_locked_gidx", gidx_rr, 2'd1);
    applyStimulus(1'b1, 3'b111, 1'b0);
    checkOutput("mrst_busy", busy_rr, 1'b0);
    checkOutput("mrst_gidx", gidx_rr, 2'd0);
    checkOutput("mrst_mem_valid", rr_if.mem_valid, 1'b0);
    checkOutput("mrst_ready", rr_if.ready, 3'b000);
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("mrst_restart_ready", rr_if.ready, 3'b001);
    checkOutput("mrst_restart_busy", busy_rr, 1'b0);

    // Fixed priority: ports 0 and 2 pending, port 2 only once port 0 drops
    applyStimulus(1'b0, 3'b101, 1'b1);
    checkOutput("fp_c1_ready", fp_if.ready, 3'b001);
    checkOutput("fp_c1_addr", fp_if.mem_addr, 32'h40);
    applyStimulus(1'b0, 3'b101, 1'b1);
    checkOutput("fp_c2_ready", fp_if.ready, 3'b001);
    applyStimulus(1'b0, 3'b101, 1'b1);
    checkOutput("fp_c3_ready", fp_if.ready, 3'b001);
    applyStimulus(1'b0, 3'b100, 1'b1);
    checkOutput("fp_drop_ready", fp_if.ready, 3'b100);
    checkOutput("fp_drop_addr", fp_if.mem_addr, 32'h200);
    checkOutput("fp_drop_wstrb", fp_if.mem_wstrb, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
